// File: rtl/ncc_data_feeder.sv
// ncc_data_feeder: producer side of the ncc descriptor/window interface.
// Collects a 256-byte descriptor, bursts it as 64 contiguous 32-bit words,
// then assembles NUM_WINDOWS 16x16 search windows, each announced by a
// one-cycle window_data_ready pulse and held until ncc acknowledges it.
//
// Optional feature macro: FEEDER_WIN_INDEX_EN adds output win_index[8:0].
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pix_in/pix_valid/ready   upstream byte stream (transfer = valid & ready)
//   desc_out/desc_data_ready descriptor word stream, 64 consecutive cycles
//   done_with_desc_data      ncc consumed the descriptor
//   window_out[row][col]     assembled 16x16 window
//   window_data_ready        one-cycle pulse, window_out valid
//   done_with_window_data    ncc finished with the current window
//   win_index (optional)     index of window currently on window_out
module ncc_data_feeder #(
    parameter int unsigned NUM_WINDOWS = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             pix_in,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    output logic [31:0]            desc_out,
    output logic                   desc_data_ready,
    input  logic                   done_with_desc_data,
    output logic [15:0][15:0][7:0] window_out,
`ifdef FEEDER_WIN_INDEX_EN
    output logic [8:0]             win_index,
`endif
    output logic                   window_data_ready,
    input  logic                   done_with_window_data
);

    localparam int unsigned DESC_WORDS = 64;
    localparam logic [8:0]  LAST_WIN   = 9'(NUM_WINDOWS - 1);

    typedef enum logic [2:0] {
        DESC_FILL, DESC_BURST, DESC_WAIT, WIN_FILL, WIN_ISSUE, WIN_WAIT
    } state_e;

    state_e                  state_q, state_d;
    logic [7:0]              byte_cnt_q, byte_cnt_d;
    logic [5:0]              word_idx_q, word_idx_d;
    logic [8:0]              win_cnt_q, win_cnt_d;
    logic                    pix_ready_q, pix_ready_d;
    logic [31:0]             desc_out_q, desc_out_d;
    logic                    desc_rdy_q, desc_rdy_d;
    logic                    win_rdy_q, win_rdy_d;
    logic [15:0][15:0][7:0]  window_q, window_d;
    logic [31:0]             desc_buf_q [DESC_WORDS];

    logic                    xfer_c;
    logic                    buf_we_c;
    logic [1:0]              lane_c;

    assign xfer_c = pix_valid & pix_ready_q;
    // Byte 4k+0 lands in [31:24], so lane index is the inverted byte offset.
    assign lane_c = ~byte_cnt_q[1:0];

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        win_cnt_d  = win_cnt_q;
        desc_out_d = '0;
        desc_rdy_d = 1'b0;
        win_rdy_d  = 1'b0;
        window_d   = window_q;
        buf_we_c   = 1'b0;

        case (state_q)
            DESC_FILL: begin
                if (xfer_c) begin
                    buf_we_c   = 1'b1;
                    byte_cnt_d = 8'(byte_cnt_q + 8'd1);
                    if (byte_cnt_q == 8'hFF) begin
                        // Word 0 is already complete; preload it for the burst.
                        state_d    = DESC_BURST;
                        word_idx_d = '0;
                        desc_rdy_d = 1'b1;
                        desc_out_d = desc_buf_q[0];
                    end
                end
            end
            DESC_BURST: begin
                if (word_idx_q == 6'd63) begin
                    // done coinciding with the last word is honoured here.
                    if (done_with_desc_data) begin
                        state_d   = WIN_FILL;
                        win_cnt_d = '0;
                    end else begin
                        state_d = DESC_WAIT;
                    end
                end else begin
                    word_idx_d = 6'(word_idx_q + 6'd1);
                    desc_rdy_d = 1'b1;
                    desc_out_d = desc_buf_q[6'(word_idx_q + 6'd1)];
                end
            end
            DESC_WAIT: begin
                if (done_with_desc_data) begin
                    state_d   = WIN_FILL;
                    win_cnt_d = '0;
                end
            end
            WIN_FILL: begin
                if (xfer_c) begin
                    window_d[byte_cnt_q[7:4]][byte_cnt_q[3:0]] = pix_in;
                    byte_cnt_d = 8'(byte_cnt_q + 8'd1);
                    if (byte_cnt_q == 8'hFF) begin
                        state_d   = WIN_ISSUE;
                        win_rdy_d = 1'b1;
                    end
                end
            end
            WIN_ISSUE, WIN_WAIT: begin
                if (done_with_window_data) begin
                    if (win_cnt_q == LAST_WIN) begin
                        state_d   = DESC_FILL;
                        win_cnt_d = '0;
                    end else begin
                        state_d   = WIN_FILL;
                        win_cnt_d = 9'(win_cnt_q + 9'd1);
                    end
                end else begin
                    state_d = WIN_WAIT;
                end
            end
            default: state_d = DESC_FILL;
        endcase

        // Registered decode of the upcoming state.
        pix_ready_d = (state_d == DESC_FILL) || (state_d == WIN_FILL);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DESC_FILL;
            byte_cnt_q  <= '0;
            word_idx_q  <= '0;
            win_cnt_q   <= '0;
            pix_ready_q <= 1'b0;
            desc_out_q  <= '0;
            desc_rdy_q  <= 1'b0;
            win_rdy_q   <= 1'b0;
            window_q    <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_idx_q  <= word_idx_d;
            win_cnt_q   <= win_cnt_d;
            pix_ready_q <= pix_ready_d;
            desc_out_q  <= desc_out_d;
            desc_rdy_q  <= desc_rdy_d;
            win_rdy_q   <= win_rdy_d;
            window_q    <= window_d;
        end
    end

    // Descriptor buffer; stale contents are never read before a full refill.
    always_ff @(posedge clk) begin
        if (buf_we_c && !rst) begin
            desc_buf_q[byte_cnt_q[7:2]][{lane_c, 3'b000} +: 8] <= pix_in;
        end
    end

    assign pix_ready         = pix_ready_q;
    assign desc_out          = desc_out_q;
    assign desc_data_ready   = desc_rdy_q;
    assign window_data_ready = win_rdy_q;
    assign window_out        = window_q;
`ifdef FEEDER_WIN_INDEX_EN
    assign win_index         = win_cnt_q;
`endif

endmodule

// File: tb/tb_ncc_data_feeder.sv
// Scoreboard bench for ncc_data_feeder (NUM_WINDOWS = 2).
module tb_ncc_data_feeder;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [7:0]             pix_in;
    logic                   pix_valid;
    logic                   pix_ready;
    logic [31:0]            desc_out;
    logic                   desc_data_ready;
    logic                   done_d;
    logic [15:0][15:0][7:0] window_out;
    logic                   window_data_ready;
    logic                   done_w;
`ifdef FEEDER_WIN_INDEX_EN
    logic [8:0]             win_index;
`endif

    int total = 0;
    int bad   = 0;
    int run_len = 0;
    int expect_len = 64;
    logic wdr_prev = 1'b0;

    logic [31:0]   desc_exp_q [$];
    logic [2047:0] win_exp_q  [$];

    ncc_data_feeder #(.NUM_WINDOWS(2)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .pix_in                (pix_in),
        .pix_valid             (pix_valid),
        .pix_ready             (pix_ready),
        .desc_out              (desc_out),
        .desc_data_ready       (desc_data_ready),
        .done_with_desc_data   (done_d),
        .window_out            (window_out),
`ifdef FEEDER_WIN_INDEX_EN
        .win_index             (win_index),
`endif
        .window_data_ready     (window_data_ready),
        .done_with_window_data (done_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_win(input string name, input logic [2047:0] exp);
        logic [2047:0] act;
        act = window_out;
        total++;
        if (act !== exp) begin
            bad++;
            for (int n = 0; n < 256; n++) begin
                if (act[n*8 +: 8] !== exp[n*8 +: 8]) begin
                    $display("FAIL %s: byte %0d got %0h want %0h", name, n,
                             act[n*8 +: 8], exp[n*8 +: 8]);
                    break;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one byte and returns one step after the edge that took it.
    task automatic send_byte(input logic [7:0] b);
        logic ok;
        int   n;
        pix_valid = 1'b1;
        pix_in    = b;
        n = 0;
        do begin
            ok = pix_ready;
            cycle();
            n++;
        end while (!ok && n < 1000);
        if (!ok) check("accept_bound", 64'(ok), 64'd1);
    endtask

    task automatic pulse_desc_done();
        done_d = 1'b1;
        cycle();
        done_d = 1'b0;
    endtask

    task automatic pulse_win_done();
        done_w = 1'b1;
        cycle();
        done_w = 1'b0;
    endtask

    task automatic wait_desc_idle();
        int n;
        n = 0;
        while (desc_data_ready && n < 200) begin
            cycle();
            n++;
        end
        if (desc_data_ready) check("burst_bound", 64'(desc_data_ready), 64'd0);
    endtask

    // Monitor: pops expected words/windows whenever the DUT presents them.
    always @(negedge clk) begin
        if (desc_data_ready) begin
            run_len++;
            check("burst_pix_ready", 64'(pix_ready), 64'd0);
            if (desc_exp_q.size() == 0) check("desc_unexpected", 64'(desc_out), 64'hDEAD);
            else check("desc_word", 64'(desc_out), 64'(desc_exp_q.pop_front()));
        end else if (run_len != 0) begin
            check("burst_len", 64'(run_len), 64'(expect_len));
            run_len = 0;
        end
        if (window_data_ready) begin
            check("win_pulse_width", 64'(wdr_prev), 64'd0);
            if (win_exp_q.size() == 0) check("win_unexpected", 64'(window_data_ready), 64'd0);
            else check_win("window", win_exp_q.pop_front());
        end
        wdr_prev = window_data_ready;
    end

    initial begin
        logic [2047:0] w;
        logic [7:0]    b [4];

        rst = 1'b1; pix_valid = 1'b0; pix_in = '0; done_d = 1'b0; done_w = 1'b0;
        repeat (3) cycle();
        check("rst_pix_ready", 64'(pix_ready), 64'd0);
        check("rst_desc_rdy", 64'(desc_data_ready), 64'd0);
        check("rst_desc_out", 64'(desc_out), 64'd0);
        check("rst_win_rdy", 64'(window_data_ready), 64'd0);
        check("rst_win_zero", 64'(window_out == '0), 64'd1);
`ifdef FEEDER_WIN_INDEX_EN
        check("rst_win_index", 64'(win_index), 64'd0);
`endif
        rst = 1'b0;
        cycle();
        check("pix_ready_after_rst", 64'(pix_ready), 64'd1);

        // Descriptor of repeated 3,4,5,6
        for (int k = 0; k < 64; k++) desc_exp_q.push_back(32'h03040506);
        for (int i = 0; i < 256; i++) send_byte(8'(3 + (i % 4)));
        pix_valid = 1'b0;
        check("burst_start", 64'(desc_data_ready), 64'd1);
        check("burst_no_ready", 64'(pix_ready), 64'd0);
        repeat (4) cycle();
        pulse_desc_done();                      // early done must be ignored
        wait_desc_idle();
        repeat (3) cycle();
        check("desc_wait_hold", 64'(pix_ready), 64'd0);
        check("desc_out_zero", 64'(desc_out), 64'd0);
        pulse_desc_done();
        check("win_fill_ready", 64'(pix_ready), 64'd1);

        // Window 0: all 2s, contiguous
        for (int n = 0; n < 256; n++) w[n*8 +: 8] = 8'd2;
        win_exp_q.push_back(w);
        for (int i = 0; i < 256; i++) send_byte(8'd2);
        pix_valid = 1'b0;
        check("win0_pulse", 64'(window_data_ready), 64'd1);
        repeat (5) cycle();
        check("win0_wait_ready", 64'(pix_ready), 64'd0);
        check("win0_pulse_gone", 64'(window_data_ready), 64'd0);
        check_win("win0_held", w);
`ifdef FEEDER_WIN_INDEX_EN
        check("win0_index", 64'(win_index), 64'd0);
`endif
        pulse_win_done();
        check("win1_fill_ready", 64'(pix_ready), 64'd1);

        // Window 1: byte n = n with pix_valid toggling, acked in issue cycle
        for (int n = 0; n < 256; n++) w[n*8 +: 8] = 8'(n);
        win_exp_q.push_back(w);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
            if (i != 255) begin
                pix_valid = 1'b0;
                cycle();
            end
        end
        pix_valid = 1'b0;
        check("win1_pulse", 64'(window_data_ready), 64'd1);
        check("win1_3_5", 64'(window_out[3][5]), 64'd53);
`ifdef FEEDER_WIN_INDEX_EN
        check("win1_index", 64'(win_index), 64'd1);
`endif
        pulse_win_done();
        check("back_to_desc_ready", 64'(pix_ready), 64'd1);

        // Descriptor 0..255, done in the last burst cycle
        for (int k = 0; k < 64; k++)
            desc_exp_q.push_back({8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)});
        for (int i = 0; i < 256; i++) send_byte(8'(i));
        pix_valid = 1'b0;
        repeat (63) cycle();
        check("last_word_visible", 64'(desc_data_ready), 64'd1);
        pulse_desc_done();
        check("late_done_ready", 64'(pix_ready), 64'd1);
        check("late_done_burst_off", 64'(desc_data_ready), 64'd0);

        // Reset from window fill, then reset again at burst word 30
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        expect_len = 31;
        for (int k = 0; k < 31; k++) desc_exp_q.push_back(32'h11111111);
        for (int i = 0; i < 256; i++) send_byte(8'h11);
        pix_valid = 1'b0;
        repeat (30) cycle();
        rst = 1'b1;
        cycle();
        check("mid_rst_desc_rdy", 64'(desc_data_ready), 64'd0);
        check("mid_rst_desc_out", 64'(desc_out), 64'd0);
        check("mid_rst_pix_ready", 64'(pix_ready), 64'd0);
        rst = 1'b0;
        repeat (2) cycle();
        expect_len = 64;

        // Fresh descriptor needed: 255 bytes give no burst
        for (int k = 0; k < 64; k++) begin
            for (int j = 0; j < 4; j++) b[j] = 8'((4*k + j) * 7 + 1);
            desc_exp_q.push_back({b[0], b[1], b[2], b[3]});
        end
        for (int i = 0; i < 255; i++) send_byte(8'(i * 7 + 1));
        pix_valid = 1'b0;
        repeat (5) cycle();
        check("no_burst_255", 64'(desc_data_ready), 64'd0);
        check("still_fill", 64'(pix_ready), 64'd1);
        send_byte(8'(255 * 7 + 1));
        pix_valid = 1'b0;
        check("burst_after_256", 64'(desc_data_ready), 64'd1);
        wait_desc_idle();
        repeat (3) cycle();

        check("desc_queue_empty", 64'(desc_exp_q.size()), 64'd0);
        check("win_queue_empty", 64'(win_exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
